noise_gen_lfsr: RTL and testbench
=================================

Name: noise_gen_lfsr

Overview:
- Self-addressing successor to the sine × log ROM noise generator.
- An internal LFSR produces the sine and log ROM addresses. The ROM outputs are multiplied as signed values, scaled by a runtime gain shift and saturated to OUT_W.
- Output is a valid/ready stream with full backpressure. The sine and log ROMs sit outside the block.
- Feeds the DDS summing stage in place of the externally addressed noise path.

Parameters:
- SIN_AW, 11, sine ROM address width
- LOG_AW, 10, log ROM address width
- DW, 8, data width of each ROM (signed)
- OUT_W, 16, output sample width (signed); must be >= 2*DW
- LFSR_W, 32, LFSR width; must be >= SIN_AW and >= LOG_AW
- TAPS, 32'h80200003, Galois feedback mask
- GSH_W, 3, gain shift width (shift 0..7)

Ports:
- clk100 in 1: system clock
- rst_n in 1: asynchronous active-low reset
- noise_en in 1: 1 = insert a new sample per advance; 0 = insert bubbles
- mode in 2: 00 product, 01 sine-only, 10 raw LFSR, 11 zero
- gain_sh in GSH_W: left-shift amount applied before saturation
- seed_load in 1: synchronous LFSR reload and pipeline flush
- seed in LFSR_W: reload value
- rom_en out 1: ROM clock enable, equals internal advance
- sin_addr out SIN_AW: sine ROM address, registered
- log_addr out LOG_AW: log ROM address, registered
- sin_data in DW: sine ROM data, 1-cycle registered latency when rom_en=1
- log_data in DW: log ROM data, same timing as sin_data
- noise_out out OUT_W: signed sample
- noise_valid out 1: noise_out is valid
- noise_ready in 1: consumer accepts the sample

Behaviour:
- Reset (rst_n=0, asynchronous):
  - lfsr=1; sin_addr=0; log_addr=0
  - All stage valids=0; noise_valid=0; noise_out=0
- advance = !noise_valid || noise_ready. The whole pipeline moves together only on advance; otherwise every register holds.
- rom_en = advance. With rom_en=0 the external ROM registers hold, so ROM data stays aligned with the held addresses.
- Stage A, on advance:
  - vA <= noise_en.
  - If noise_en=1: lfsr steps, then sin_addr <= lfsr_next[SIN_AW-1:0] and log_addr <= lfsr_next[LFSR_W-1 -: LOG_AW].
  - LFSR step: lfsr_next = lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1.
- Stage R, on advance: vR <= vA. The ROM data is the contents at the stage-A address.
- Stage P, on advance: vP <= vR; mode is sampled here.
  - Mode 00: p = signed(sin_data) × signed(log_data), 2*DW bits.
  - Mode 01: p = sin_data sign-extended.
  - Mode 10: p = low 2*DW bits of lfsr.
  - Mode 11: p = 0.
- Stage O, on advance: noise_valid <= vP; gain_sh is sampled here.
  - s = sign-extend(p) << gain_sh, computed at 2*DW+2^GSH_W bits.
  - noise_out = s clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - noise_out is updated only when vP=1; on a bubble it keeps its last value.
- Latency:
  - noise_en rising with noise_ready=1: first noise_valid 4 cycles later.
  - Throughput: 1 sample/cycle.
- Backpressure (noise_valid=1, noise_ready=0):
  - noise_out, addresses and lfsr are frozen.
  - No sample is dropped or duplicated.
- noise_en=0: the pipeline drains. Samples already in flight still emerge; lfsr does not step.
- seed_load=1 (priority over advance):
  - lfsr <= (seed==0) ? 1 : seed.
  - vA=vR=vP=noise_valid=0; addresses unchanged.
  - The first post-load sample uses step(seed).
- Simultaneous seed_load and noise_ready: the load wins and the current output is discarded.
- Reset mid-stream: noise_valid drops immediately and asynchronously.
- LFSR never reaches all-zero; period is 2^32-1 for the default TAPS.

Test Plan:
1. Reset, then release with noise_en=0 -> noise_valid=0, noise_out=0, sin_addr=0, log_addr=0, lfsr=1, rom_en=1.
2. seed_load with seed=1, then noise_en=1, ready=1 -> first advance gives lfsr=0x80200003, sin_addr=0x003, log_addr=0x200; noise_valid first high 4 cycles after noise_en.
3. ROM model returns sin=0x7F, log=0x7F -> gain 0 gives 0x3F01; gain 1 gives 0x7E02; gain 2 saturates to 0x7FFF. sin=0x80, log=0x7F, gain 2 -> 0x8000.
4. Free-running with noise_ready low for 5 cycles mid-stream -> noise_out held, rom_en=0; the emitted sequence matches a golden LFSR/ROM model with no gaps or repeats.
5. seed_load asserted with 3 samples in flight and ready=1 -> noise_valid=0 the next cycle; the next valid sample is derived from step(seed); seed=0 behaves as seed=1.
6. Modes 01/10/11 with sin=0x9C -> 0xFF9C, lfsr[15:0], 0x0000 respectively. Toggling noise_en 1-0-1 -> bubbles pass through and lfsr advances only on accepted samples.

Source files
------------

// File: rtl/noise_gen_lfsr.sv
// noise_gen_lfsr
// Self-addressing noise source. A Galois LFSR supplies the sine and log ROM
// addresses. The two signed ROM words are multiplied, scaled by a runtime
// left shift and clipped to OUT_W. The result goes out as a valid/ready
// stream with full backpressure. The sine and log ROMs are outside this block
// and have one registered cycle of latency, gated by rom_en.
//
// Ports
//   clk100      system clock
//   rst_n       asynchronous active-low reset
//   noise_en    1 = launch a new sample on each advance, 0 = launch bubbles
//   mode        00 product, 01 sine only, 10 raw LFSR, 11 zero
//   gain_sh     left shift applied before saturation
//   seed_load   synchronous LFSR reload and pipeline flush
//   seed        reload value (zero is replaced by 1)
//   rom_en      ROM clock enable, equal to the internal advance
//   sin_addr    registered sine ROM address
//   log_addr    registered log ROM address
//   sin_data    sine ROM data, one registered cycle after the address
//   log_data    log ROM data, same timing as sin_data
//   noise_out   signed output sample
//   noise_valid noise_out holds a sample
//   noise_ready consumer accepts the sample
//
// Pipeline: A (LFSR step and address) -> R (ROM read) -> P (product / mode)
// -> O (gain, saturate, output register). Every stage moves together on
// advance and holds otherwise, so nothing is dropped or duplicated.

module noise_gen_lfsr #(
  parameter int                SIN_AW = 11,
  parameter int                LOG_AW = 10,
  parameter int                DW     = 8,
  parameter int                OUT_W  = 16,
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = 32'h80200003,
  parameter int                GSH_W  = 3
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              noise_en,
  input  logic [1:0]        mode,
  input  logic [GSH_W-1:0]  gain_sh,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              rom_en,
  output logic [SIN_AW-1:0] sin_addr,
  output logic [LOG_AW-1:0] log_addr,
  input  logic [DW-1:0]     sin_data,
  input  logic [DW-1:0]     log_data,
  output logic [OUT_W-1:0]  noise_out,
  output logic              noise_valid,
  input  logic              noise_ready
);

  // Product width, widest shifted value, and the width used for the
  // saturation compare. The compare width never drops below OUT_W.
  localparam int PW = 2 * DW;
  localparam int SW = PW + (1 << GSH_W);
  localparam int XW = (SW > OUT_W) ? SW : OUT_W;

  localparam logic [LFSR_W-1:0] LFSR_ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

  // Saturation limits: first in the compare width, then in the output width.
  localparam logic signed [XW-1:0] SAT_HI =
    {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_LO =
    {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_HI = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_LO = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_PRODUCT = 2'b00,
    MODE_SINE    = 2'b01,
    MODE_RAW     = 2'b10,
    MODE_ZERO    = 2'b11
  } mode_t;

  logic                     advance;
  logic [LFSR_W-1:0]        lfsr;
  logic [LFSR_W-1:0]        lfsr_next;
  logic [LFSR_W-1:0]        seed_safe;
  logic                     v_a;
  logic                     v_r;
  logic                     v_p;
  logic [PW-1:0]            lfsr_r;
  logic signed [PW-1:0]     sin_ext;
  logic signed [PW-1:0]     log_ext;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     p_next;
  logic signed [PW-1:0]     p_reg;
  logic signed [XW-1:0]     s_ext;
  logic signed [XW-1:0]     s_shift;
  logic [OUT_W-1:0]         sat;

  // The output register frees up when it is empty or being consumed. The
  // whole pipeline, and the external ROM registers, move on that condition.
  assign advance = !noise_valid || noise_ready;
  assign rom_en  = advance;

  // One Galois step. The register can never reach zero because the reload
  // path replaces a zero seed with 1.
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign seed_safe = (seed == '0) ? LFSR_ONE : seed;

  // Stage A: step the LFSR and present the new addresses to the ROMs. The
  // LFSR steps only when a real sample is launched, so bubbles do not use up
  // sequence values. A seed load leaves the addresses alone. Whatever the
  // ROMs read in the meantime belongs to flushed slots and is never used.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_ONE;
      sin_addr <= '0;
      log_addr <= '0;
      v_a      <= 1'b0;
    end else if (seed_load) begin
      lfsr <= seed_safe;
      v_a  <= 1'b0;
    end else if (advance) begin
      v_a <= noise_en;
      if (noise_en) begin
        lfsr     <= lfsr_next;
        sin_addr <= lfsr_next[SIN_AW-1:0];
        log_addr <= lfsr_next[LFSR_W-1 -: LOG_AW];
      end
    end
  end

  // Stage R: the external ROMs register the stage-A addresses. The low LFSR
  // bits travel alongside so the raw-LFSR mode reports the same state that
  // produced this slot's addresses. At this edge the live LFSR still holds
  // that state, even if it steps again on the same edge.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      v_r    <= 1'b0;
      lfsr_r <= '0;
    end else if (seed_load) begin
      v_r <= 1'b0;
    end else if (advance) begin
      v_r    <= v_a;
      lfsr_r <= lfsr[PW-1:0];
    end
  end

  // Select the pre-gain value for the current mode. Both ROM words are
  // sign-extended to the product width first. The low PW bits of a PW x PW
  // multiply are then the exact DW x DW signed product.
  always_comb begin
    sin_ext = {{DW{sin_data[DW-1]}}, sin_data};
    log_ext = {{DW{log_data[DW-1]}}, log_data};
    prod    = sin_ext * log_ext;
    p_next  = '0;
    case (mode_t'(mode))
      MODE_PRODUCT: p_next = prod;
      MODE_SINE:    p_next = sin_ext;
      MODE_RAW:     p_next = lfsr_r;
      MODE_ZERO:    p_next = '0;
      default:      p_next = '0;
    endcase
  end

  // Stage P: register the mode-selected value.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      v_p   <= 1'b0;
      p_reg <= '0;
    end else if (seed_load) begin
      v_p <= 1'b0;
    end else if (advance) begin
      v_p   <= v_r;
      p_reg <= p_next;
    end
  end

  // Apply the gain shift at a width large enough that no bits are lost,
  // then clip to the signed OUT_W range.
  always_comb begin
    s_ext   = {{(XW-PW){p_reg[PW-1]}}, p_reg};
    s_shift = s_ext <<< gain_sh;
    if (s_shift > SAT_HI) begin
      sat = OUT_HI;
    end else if (s_shift < SAT_LO) begin
      sat = OUT_LO;
    end else begin
      sat = s_shift[OUT_W-1:0];
    end
  end

  // Stage O: the output register. A bubble clears valid but keeps the last
  // sample value on the bus.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      noise_valid <= 1'b0;
      noise_out   <= '0;
    end else if (seed_load) begin
      noise_valid <= 1'b0;
    end else if (advance) begin
      noise_valid <= v_p;
      if (v_p) begin
        noise_out <= sat;
      end
    end
  end

endmodule

// File: tb/tb_noise_gen_lfsr.sv
// tb_noise_gen_lfsr
// Bench for noise_gen_lfsr. A registered ROM model is attached to the
// address ports. A reference model treats the accepted output stream as the
// LFSR sequence starting after the seed, with each state mapped through the
// ROM contents and the mode, gain and saturation rules. A free-running
// compare process checks every accepted sample against that model. Directed
// literals check reset values, latency, saturation corners, modes, flushes
// and reset in the middle of a stream.

module tb_noise_gen_lfsr;

  localparam int          SIN_AW = 11;
  localparam int          LOG_AW = 10;
  localparam int          DW     = 8;
  localparam int          OUT_W  = 16;
  localparam int          LFSR_W = 32;
  localparam int          GSH_W  = 3;
  localparam logic [31:0] TAPS   = 32'h80200003;

  logic              clk100 = 1'b0;
  logic              rst_n;
  logic              noise_en;
  logic [1:0]        mode;
  logic [GSH_W-1:0]  gain_sh;
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              rom_en;
  logic [SIN_AW-1:0] sin_addr;
  logic [LOG_AW-1:0] log_addr;
  logic [DW-1:0]     sin_data = '0;
  logic [DW-1:0]     log_data = '0;
  logic [OUT_W-1:0]  noise_out;
  logic              noise_valid;
  logic              noise_ready;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  sin_mem [2048];
  logic [7:0]  log_mem [1024];

  logic [31:0] model_state;
  int          accepted;
  logic        prev_stall;
  logic [15:0] held_out;

  always #5 clk100 = ~clk100;

  noise_gen_lfsr dut (
    .clk100      (clk100),
    .rst_n       (rst_n),
    .noise_en    (noise_en),
    .mode        (mode),
    .gain_sh     (gain_sh),
    .seed_load   (seed_load),
    .seed        (seed),
    .rom_en      (rom_en),
    .sin_addr    (sin_addr),
    .log_addr    (log_addr),
    .sin_data    (sin_data),
    .log_data    (log_data),
    .noise_out   (noise_out),
    .noise_valid (noise_valid),
    .noise_ready (noise_ready)
  );

  // External ROMs: registered read, held while rom_en is low.
  always @(posedge clk100) begin
    if (rom_en) begin
      sin_data <= sin_mem[sin_addr];
      log_data <= log_mem[log_addr];
    end
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  // Expected output for one LFSR state under a given mode and gain.
  function automatic logic [15:0] expected_sample(input logic [31:0] st,
                                                  input logic [1:0] md,
                                                  input logic [2:0] gs);
    int     p;
    longint v;
    logic [15:0] low;
    low = st[15:0];
    case (md)
      2'b00:   p = int'($signed(sin_mem[st[10:0]])) * int'($signed(log_mem[st[31:22]]));
      2'b01:   p = int'($signed(sin_mem[st[10:0]]));
      2'b10:   p = int'($signed(low));
      default: p = 0;
    endcase
    v = longint'(p) * (longint'(1) << gs);
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Load a seed, flush the pipeline and set up this segment's ROM contents,
  // mode and gain. The changes are made in the load cycle, so no surviving
  // sample ever sees mixed configuration.
  task automatic applyStimulus(input logic [31:0] seed_v, input logic [1:0] md,
                               input logic [2:0] gs, input bit use_const,
                               input logic [7:0] sv, input logic [7:0] lv,
                               input logic en);
    @(posedge clk100);
    #1;
    for (int i = 0; i < 2048; i++) sin_mem[i] = use_const ? sv : 8'(i * 37 + 5);
    for (int i = 0; i < 1024; i++) log_mem[i] = use_const ? lv : 8'(i * 13 + 91);
    mode      = md;
    gain_sh   = gs;
    seed      = seed_v;
    seed_load = 1'b1;
    @(posedge clk100);
    #1;
    seed_load = 1'b0;
    noise_en  = en;
  endtask

  // Wait (bounded) for the next valid sample and return it.
  task automatic waitValid(input string name, output logic [15:0] val);
    int n;
    n = 0;
    @(negedge clk100);
    while (!noise_valid && n < 20) begin
      @(negedge clk100);
      n++;
    end
    checkOutput({name, "_valid"}, noise_valid, 1);
    val = noise_out;
  endtask

  // Compare process. Inputs change 1 ns after each rising edge, so at the
  // falling edge this sees exactly what the next rising edge will sample.
  initial begin
    logic [31:0] nxt;
    model_state = 32'h1;
    accepted    = 0;
    prev_stall  = 1'b0;
    held_out    = '0;
    forever begin
      @(negedge clk100);
      if (!rst_n) begin
        model_state = 32'h1;
        accepted    = 0;
        prev_stall  = 1'b0;
      end else begin
        checkOutput("rom_en_rule", rom_en, !noise_valid || noise_ready);
        if (prev_stall) begin
          checkOutput("stall_valid", noise_valid, 1);
          checkOutput("stall_hold", noise_out, held_out);
        end
        if (seed_load) begin
          model_state = (seed == 0) ? 32'h1 : seed;
          accepted    = 0;
          prev_stall  = 1'b0;
        end else if (noise_valid && noise_ready) begin
          nxt = lfsr_step(model_state);
          checkOutput("stream", noise_out, expected_sample(nxt, mode, gain_sh));
          model_state = nxt;
          accepted++;
          prev_stall = 1'b0;
        end else if (noise_valid) begin
          prev_stall = 1'b1;
          held_out   = noise_out;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] v;
    logic [31:0] st;
    int          cycles;
    logic        pat [10];

    rst_n       = 1'b0;
    noise_en    = 1'b0;
    mode        = 2'b00;
    gain_sh     = '0;
    seed_load   = 1'b0;
    seed        = '0;
    noise_ready = 1'b1;
    for (int i = 0; i < 2048; i++) sin_mem[i] = 8'(i * 37 + 5);
    for (int i = 0; i < 1024; i++) log_mem[i] = 8'(i * 13 + 91);

    // Reset, then release with noise_en low.
    repeat (3) @(posedge clk100);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk100);
    checkOutput("reset_valid", noise_valid, 0);
    checkOutput("reset_out", noise_out, 0);
    checkOutput("reset_sin_addr", sin_addr, 0);
    checkOutput("reset_log_addr", log_addr, 0);
    checkOutput("reset_lfsr", dut.lfsr, 1);
    checkOutput("reset_rom_en", rom_en, 1);

    // Seed 1: first step and address split, then four-cycle latency.
    applyStimulus(32'h1, 2'b00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk100);
    @(negedge clk100);
    checkOutput("step1_lfsr", dut.lfsr, 32'h80200003);
    checkOutput("step1_sin_addr", sin_addr, 11'h003);
    checkOutput("step1_log_addr", log_addr, 10'h200);
    cycles = 1;
    while (!noise_valid && cycles < 10) begin
      @(negedge clk100);
      cycles++;
    end
    checkOutput("first_valid_latency", cycles, 4);
    repeat (6) @(posedge clk100);

    // Gain and saturation corners with constant ROM contents.
    applyStimulus(32'h00000BAD, 2'b00, 3'd0, 1'b1, 8'h7F, 8'h7F, 1'b1);
    waitValid("gain0", v);
    checkOutput("gain0", v, 16'h3F01);
    applyStimulus(32'h00000BAD, 2'b00, 3'd1, 1'b1, 8'h7F, 8'h7F, 1'b1);
    waitValid("gain1", v);
    checkOutput("gain1", v, 16'h7E02);
    applyStimulus(32'h00000BAD, 2'b00, 3'd2, 1'b1, 8'h7F, 8'h7F, 1'b1);
    waitValid("gain2_pos_sat", v);
    checkOutput("gain2_pos_sat", v, 16'h7FFF);
    applyStimulus(32'h00000BAD, 2'b00, 3'd2, 1'b1, 8'h80, 8'h7F, 1'b1);
    waitValid("gain2_neg_sat", v);
    checkOutput("gain2_neg_sat", v, 16'h8000);

    // Free-running stream with five cycles of backpressure.
    applyStimulus(32'h1234ABCD, 2'b00, 3'd3, 1'b0, 8'h00, 8'h00, 1'b1);
    repeat (10) @(posedge clk100);
    #1 noise_ready = 1'b0;
    repeat (5) begin
      @(negedge clk100);
      checkOutput("stall_rom_en", rom_en, 0);
    end
    @(posedge clk100);
    #1 noise_ready = 1'b1;
    repeat (10) @(posedge clk100);

    // Seed load with samples in flight, then seed 0 acting as seed 1.
    applyStimulus(32'hDEADBEEF, 2'b10, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk100);
    checkOutput("flush_valid", noise_valid, 0);
    waitValid("reload_raw", v);
    checkOutput("reload_raw", v, 16'hDF74);
    applyStimulus(32'h0, 2'b10, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1);
    waitValid("seed0_raw", v);
    checkOutput("seed0_raw", v, 16'h0003);

    // Remaining modes.
    applyStimulus(32'h5A5A0001, 2'b01, 3'd0, 1'b1, 8'h9C, 8'h11, 1'b1);
    waitValid("mode_sine", v);
    checkOutput("mode_sine", v, 16'hFF9C);
    applyStimulus(32'h5A5A0001, 2'b11, 3'd0, 1'b1, 8'h9C, 8'h11, 1'b1);
    waitValid("mode_zero", v);
    checkOutput("mode_zero", v, 16'h0000);
    applyStimulus(32'h00000002, 2'b10, 3'd0, 1'b1, 8'h9C, 8'h11, 1'b1);
    waitValid("mode_raw", v);
    checkOutput("mode_raw", v, 16'h0001);

    // noise_en toggling: bubbles pass and the LFSR steps once per sample.
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    applyStimulus(32'hC0FFEE01, 2'b00, 3'd1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      noise_en = pat[i];
      @(posedge clk100);
      #1;
    end
    noise_en = 1'b0;
    repeat (8) @(posedge clk100);
    @(negedge clk100);
    checkOutput("toggle_count", accepted, 6);
    st = 32'hC0FFEE01;
    for (int i = 0; i < 6; i++) st = lfsr_step(st);
    checkOutput("toggle_lfsr", dut.lfsr, st);

    // Reset in the middle of a stream clears the outputs immediately.
    applyStimulus(32'h13579BDF, 2'b00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1);
    repeat (8) @(posedge clk100);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", noise_valid, 0);
    checkOutput("async_reset_out", noise_out, 0);
    checkOutput("async_reset_lfsr", dut.lfsr, 1);
    checkOutput("async_reset_sin_addr", sin_addr, 0);
    noise_en = 1'b0;
    @(posedge clk100);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
